// File: rtl/i2s_rx_sequencer.sv
// I2S receiver: slot sequencer capturing one word per WS half-frame into a small sample FIFO.
// Optional macro I2S_RX_LEFT_JUSTIFIED_EN removes the one-slot data delay (left-justified framing).
module i2s_rx_sequencer #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOTS_PER_HALF = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          data_in,
    output logic                          ws,
    output logic [NUMBER_OF_BITS-1:0]     sample_out,
    output logic                          sample_channel,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow
);
    localparam int SW = (SLOTS_PER_HALF > 1) ? $clog2(SLOTS_PER_HALF) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int FIRST_BIT_SLOT = 0;
`else
    localparam int FIRST_BIT_SLOT = 1;
`endif

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

    localparam state_t        START_STATE = (FIRST_BIT_SLOT == 0) ? SHIFT : DELAY;
    localparam logic [SW-1:0] SLOT_END    = SW'(SLOTS_PER_HALF - 1);
    localparam logic [SW-1:0] LSB_SLOT    = SW'(FIRST_BIT_SLOT + NUMBER_OF_BITS - 1);
    localparam logic [LW-1:0] FULL        = LW'(FIFO_DEPTH);

    state_t                    state;
    logic [SW-1:0]             slot;
    logic [NUMBER_OF_BITS-1:0] shreg;
    logic [NUMBER_OF_BITS-1:0] shift_word;
    logic                      push;

    assign shift_word = {shreg[NUMBER_OF_BITS-2:0], data_in};
    assign push       = (state == SHIFT) && (slot == LSB_SLOT);

    // Enable is only honoured at half-frame boundaries so a started half always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            slot  <= '0;
            ws    <= 1'b0;
            shreg <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                state <= START_STATE;
                slot  <= '0;
                ws    <= 1'b0;
            end
        end else begin
            if (state == SHIFT) begin
                shreg <= shift_word;
            end
            if (slot == SLOT_END) begin
                slot <= '0;
                if (enable) begin
                    state <= START_STATE;
                    ws    <= ~ws;
                end else begin
                    state <= IDLE;
                    ws    <= 1'b0;
                end
            end else begin
                slot <= slot + 1'b1;
                if (state == DELAY) begin
                    state <= SHIFT;
                end else if ((state == SHIFT) && (slot == LSB_SLOT)) begin
                    state <= PAD;
                end
            end
        end
    end

    logic [NUMBER_OF_BITS:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [LW-1:0]           count;
    logic                    pop;
    logic                    accept;
    logic                    drop;

    // A simultaneous pop frees the slot, so a full FIFO still accepts the new word.
    assign sample_valid = (count != '0);
    assign pop          = sample_valid && sample_ready;
    assign accept       = push && ((count != FULL) || pop);
    assign drop         = push && !accept;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {ws, shift_word};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign sample_out     = sample_valid ? mem[rd_ptr][NUMBER_OF_BITS-1:0] : '0;
    assign sample_channel = sample_valid ? mem[rd_ptr][NUMBER_OF_BITS] : 1'b0;
    assign fifo_level     = count;

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Self-checking bench for i2s_rx_sequencer; builds with or without I2S_RX_LEFT_JUSTIFIED_EN.
module tb_i2s_rx_sequencer;
    localparam int NB  = 8;
    localparam int SPH = 16;
    localparam int FD  = 4;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          data_in = 1'b0;
    logic          ws;
    logic [NB-1:0] sample_out;
    logic          sample_channel;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          clear_overflow = 1'b0;

    always #5 clk = ~clk;

    i2s_rx_sequencer #(.NUMBER_OF_BITS(NB), .SLOTS_PER_HALF(SPH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .ws(ws),
        .sample_out(sample_out), .sample_channel(sample_channel), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fifo_level(fifo_level), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    int            n_tests = 0;
    int            n_fail = 0;
    logic [NB:0]   model_q[$];
    logic          model_ovf = 1'b0;
    logic [NB-1:0] tx_words [16];
    int            valid_edges[$];
    logic [NB:0]   valid_words[$];

    // Drive nh half-frames carrying tx_words[]; enable drops at slot 5 of the last half.
    // Edge k=1 leaves IDLE; edge k>=2 ends slot (k-2)%SPH of half (k-2)/SPH.
    task automatic run_frames(input int nh, input int mode, input int clr_k);
        int s, h, sz, exp_ws;
        logic push_e, pop_e, drop_e;
        enable = 1'b1;
        for (int k = 1; k <= nh*SPH+1; k++) begin
            if (k >= 2) begin s = (k-2) % SPH; h = (k-2) / SPH; end
            else begin s = -1; h = 0; end
            if (s >= FIRST && s < FIRST+NB) data_in = tx_words[h][NB-1-(s-FIRST)];
            else data_in = 1'($urandom_range(0, 1));
            case (mode)
                0: sample_ready = 1'b1;
                1: sample_ready = 1'b0;
                2: sample_ready = 1'($urandom_range(0, 1));
                default: sample_ready = (h == nh-1) && (s == FIRST+NB-1);
            endcase
            if (h == nh-1 && s == 5) enable = 1'b0;
            clear_overflow = (k == clr_k);
            sz = model_q.size();
            pop_e = sample_ready && (sz != 0);
            push_e = (s == FIRST+NB-1);
            drop_e = push_e && (sz == FD) && !pop_e;
            @(posedge clk); #1;
            if (pop_e) void'(model_q.pop_front());
            if (push_e && !drop_e) model_q.push_back({1'(h % 2), tx_words[h]});
            if (drop_e) model_ovf = 1'b1;
            else if (clear_overflow) model_ovf = 1'b0;
            clear_overflow = 1'b0;
            exp_ws = (k == nh*SPH+1) ? 0 : ((k-1) / SPH) % 2;
            if (sample_valid) begin valid_edges.push_back(k); valid_words.push_back({sample_channel, sample_out}); end
            n_tests++;
            if (sample_valid !== (model_q.size() != 0)) begin
                n_fail++; $display("FAIL frame_valid k=%0d: got %0b expected %0b", k, sample_valid, model_q.size() != 0);
            end
            n_tests++;
            if (int'(fifo_level) !== model_q.size()) begin
                n_fail++; $display("FAIL frame_level k=%0d: got %0d expected %0d", k, fifo_level, model_q.size());
            end
            n_tests++;
            if (ws !== 1'(exp_ws)) begin
                n_fail++; $display("FAIL frame_ws k=%0d: got %0b expected %0b", k, ws, exp_ws);
            end
            n_tests++;
            if (overflow !== model_ovf) begin
                n_fail++; $display("FAIL frame_ovf k=%0d: got %0b expected %0b", k, overflow, model_ovf);
            end
            if (model_q.size() != 0) begin
                n_tests++;
                if ({sample_channel, sample_out} !== model_q[0]) begin
                    n_fail++; $display("FAIL frame_head k=%0d: got %0h expected %0h", k, {sample_channel, sample_out}, model_q[0]);
                end
            end
        end
    endtask

    // Enable held low: FIFO drains, nothing new may arrive, ws stays 0.
    task automatic idle_check(input int n, input int rmode);
        logic pop_e;
        enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = 1'($urandom_range(0, 1));
            sample_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            pop_e = sample_ready && (model_q.size() != 0);
            @(posedge clk); #1;
            if (pop_e) void'(model_q.pop_front());
            n_tests++;
            if (int'(fifo_level) !== model_q.size()) begin
                n_fail++; $display("FAIL idle_level i=%0d: got %0d expected %0d", i, fifo_level, model_q.size());
            end
            n_tests++;
            if (ws !== 1'b0 || overflow !== model_ovf) begin
                n_fail++; $display("FAIL idle_ws_ovf i=%0d: got %0b/%0b expected 0/%0b", i, ws, overflow, model_ovf);
            end
            if (model_q.size() != 0) begin
                n_tests++;
                if (sample_valid !== 1'b1 || {sample_channel, sample_out} !== model_q[0]) begin
                    n_fail++; $display("FAIL idle_head i=%0d: got %0b/%0h expected 1/%0h", i, sample_valid, {sample_channel, sample_out}, model_q[0]);
                end
            end
        end
        sample_ready = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({ws, sample_out, sample_channel, sample_valid, fifo_level, overflow} !== '0) begin
            n_fail++; $display("FAIL reset_init: got %0h expected 0", {ws, sample_out, sample_channel, sample_valid, fifo_level, overflow});
        end
        reset = 1'b0;
        idle_check(30, 0);
        n = $urandom_range(20, 90);
        enable = 1'b1;
        repeat (n) begin data_in = 1'($urandom_range(0, 1)); @(posedge clk); end
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (ws !== 1'b0 || sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL reset_mid_ctrl n=%0d: got ws=%0b v=%0b lvl=%0d expected 0", n, ws, sample_valid, fifo_level);
        end
        n_tests++;
        if (sample_out !== '0 || sample_channel !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_data n=%0d: got %0h/%0b/%0b expected 0", n, sample_out, sample_channel, overflow);
        end
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk); #2;
        enable = 1'b0;
        reset = 1'b0;
        idle_check(20, 1);
    endtask

    task automatic test_basic;
        tx_words[0] = 8'hA5;
        tx_words[1] = 8'h3C;
        valid_edges.delete();
        valid_words.delete();
        run_frames(2, 0, -1);
        n_tests++;
        if (valid_edges.size() !== 2) begin
            n_fail++; $display("FAIL basic_pulses: got %0d expected 2", valid_edges.size());
        end else begin
            n_tests++;
            if (valid_edges[0] !== FIRST+9 || valid_edges[1] !== FIRST+25) begin
                n_fail++; $display("FAIL basic_timing: got %0d,%0d expected %0d,%0d", valid_edges[0], valid_edges[1], FIRST+9, FIRST+25);
            end
            n_tests++;
            if (valid_words[0] !== 9'h0A5 || valid_words[1] !== 9'h13C) begin
                n_fail++; $display("FAIL basic_words: got %0h,%0h expected a5,13c", valid_words[0], valid_words[1]);
            end
        end
        idle_check(4, 1);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 6; i++) tx_words[i] = 8'(i + 1);
        run_frames(6, 1, 2 + 5*SPH + FIRST + NB - 1);
        n_tests++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_full: got lvl=%0d ovf=%0b expected 4/1", fifo_level, overflow);
        end
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (sample_valid !== 1'b1 || sample_out !== 8'(i + 1)) begin
                n_fail++; $display("FAIL ovf_pop%0d: got %0b/%0h expected 1/%0h", i, sample_valid, sample_out, i + 1);
            end
            @(posedge clk); #1;
            void'(model_q.pop_front());
        end
        sample_ready = 1'b0;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        model_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL ovf_clear: got ovf=%0b lvl=%0d expected 0/0", overflow, fifo_level);
        end
    endtask

    task automatic test_push_pop_full;
        for (int i = 0; i < 5; i++) tx_words[i] = 8'($urandom);
        run_frames(5, 3, -1);
        n_tests++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got lvl=%0d ovf=%0b expected 4/0", fifo_level, overflow);
        end
        sample_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_tests++;
            if ({sample_channel, sample_out} !== {1'(i % 2), tx_words[i]}) begin
                n_fail++; $display("FAIL full_order%0d: got %0h expected %0h", i, {sample_channel, sample_out}, {1'(i % 2), tx_words[i]});
            end
            @(posedge clk); #1;
            void'(model_q.pop_front());
        end
        sample_ready = 1'b0;
    endtask

    task automatic test_enable_drop;
        tx_words[0] = 8'($urandom);
        tx_words[1] = 8'($urandom);
        run_frames(2, 1, -1);
        n_tests++;
        if (fifo_level !== 3'd2 || ws !== 1'b0) begin
            n_fail++; $display("FAIL drop_tail: got lvl=%0d ws=%0b expected 2/0", fifo_level, ws);
        end
        idle_check(40, 0);
        idle_check(6, 1);
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) tx_words[i] = 8'($urandom);
            run_frames(6, 2, -1);
            idle_check(10, 2);
        end
        idle_check(8, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_enable_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
